// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load returns onto the register file write port.
// Optional forwarding lookup over in-flight writes is enabled with the WB_BYPASS_EN macro.
module wb_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [ADDR_W-1:0]               alu_reg,
  input  logic [DATA_W-1:0]               alu_data,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [ADDR_W-1:0]               ld_reg,
  input  logic [DATA_W-1:0]               ld_data,
  output logic                            RegWrite,
  output logic [ADDR_W-1:0]               Write_Reg,
  output logic [DATA_W-1:0]               Write_Bus,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            wb_busy,
  input  logic [ADDR_W-1:0]               query_reg,
  output logic                            query_hit,
  output logic [DATA_W-1:0]               query_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] fifo_reg_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [STV_W-1:0]  starve_reg, starve_next;
  logic              fifo_empty, fifo_full, fifo_wins, alu_wins, push, pop;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == DEPTH_CNT);
    // The head is forced through when it has starved long enough or the buffer is full.
    fifo_wins  = !fifo_empty && (!alu_valid || (starve_reg == STARVE_MAX) || fifo_full);
    alu_wins   = alu_valid && !fifo_wins;
    push       = ld_valid && !fifo_full;
    pop        = fifo_wins;
    win_reg    = fifo_wins ? fifo_reg_mem[rd_ptr_reg]  : alu_reg;
    win_data   = fifo_wins ? fifo_data_mem[rd_ptr_reg] : alu_data;

    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!push && pop)
      count_next = count_reg - CNT_W'(1);

    starve_next = starve_reg;
    if (fifo_empty || fifo_wins)
      starve_next = '0;
    else if (starve_reg != STARVE_MAX)
      starve_next = starve_reg + STV_W'(1);
  end

  assign alu_ready  = alu_wins;
  assign ld_ready   = !fifo_full;
  assign fifo_count = count_reg;
  assign wb_busy    = !fifo_empty || RegWrite;

  // Storage carries no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_mem[wr_ptr_reg]  <= ld_reg;
      fifo_data_mem[wr_ptr_reg] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      RegWrite   <= 1'b0;
      Write_Reg  <= '0;
      Write_Bus  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg  <= count_next;
      starve_reg <= starve_next;
      if (fifo_wins || alu_wins) begin
        Write_Reg <= win_reg;
        Write_Bus <= win_data;
        RegWrite  <= (win_reg != '0);
      end else begin
        RegWrite  <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [FIFO_DEPTH-1:0] slot_hit;
  logic [DATA_W-1:0]     slot_data [FIFO_DEPTH];

  // Slot gi is the gi-th oldest live entry, so higher slots are newer.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] slot_idx;
    assign slot_idx      = rd_ptr_reg + PTR_W'(gi);
    assign slot_hit[gi]  = (CNT_W'(gi) < count_reg) && (fifo_reg_mem[slot_idx] == query_reg);
    assign slot_data[gi] = fifo_data_mem[slot_idx];
  end

  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    if (query_reg != '0) begin
      if (RegWrite && (Write_Reg == query_reg)) begin
        query_hit  = 1'b1;
        query_data = Write_Bus;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (slot_hit[i]) begin
          query_hit  = 1'b1;
          query_data = slot_data[i];
        end
      end
    end
  end
`else
  logic unused_query;
  assign unused_query = ^query_reg;
  assign query_hit    = 1'b0;
  assign query_data   = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by random traffic
// checked against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 4, LIMIT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, alu_valid, alu_ready, ld_valid, ld_ready;
  logic [AW-1:0] alu_reg, ld_reg, Write_Reg, query_reg;
  logic [DW-1:0] alu_data, ld_data, Write_Bus, query_data;
  logic          RegWrite, wb_busy, query_hit;
  logic [2:0]    fifo_count;

  wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Bus(Write_Bus),
    .fifo_count(fifo_count), .wb_busy(wb_busy),
    .query_reg(query_reg), .query_hit(query_hit), .query_data(query_data)
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: pending loads in arrival order plus the visible write port.
  ent_t          mq[$];
  int            m_starve;
  logic          m_rw;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wbus;
  logic          exp_alu_ready, exp_ld_ready, got_alu_ready, got_ld_ready;
  int            tests = 0;
  int            failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_rw     = 1'b0;
    m_wreg   = '0;
    m_wbus   = '0;
  endtask

  task automatic model_query(output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WB_BYPASS_EN
    if (query_reg != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].r == query_reg) begin
          hit  = 1'b1;
          data = mq[i].d;
          break;
        end
      end
      if (!hit && m_rw && m_wreg == query_reg) begin
        hit  = 1'b1;
        data = m_wbus;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    logic          qh;
    logic [DW-1:0] qd;
    model_query(qh, qd);
    chk("RegWrite", RegWrite, m_rw);
    chk("Write_Reg", Write_Reg, m_wreg);
    chk("Write_Bus", Write_Bus, m_wbus);
    chk("fifo_count", fifo_count, mq.size());
    chk("wb_busy", wb_busy, (mq.size() != 0) || m_rw);
    chk("query_hit", query_hit, qh);
    chk("query_data", query_data, qd);
  endtask

  // One clock: inputs were driven at posedge+1 by the caller.
  task automatic step();
    logic fw;
    int   n;
    ent_t e;
    #2;
    n  = mq.size();
    fw = (n > 0) && (!alu_valid || m_starve >= LIMIT || n == DEPTH);
    exp_alu_ready = alu_valid && !fw;
    exp_ld_ready  = (n < DEPTH);
    got_alu_ready = alu_ready;
    got_ld_ready  = ld_ready;
    chk("alu_ready", alu_ready, exp_alu_ready);
    chk("ld_ready", ld_ready, exp_ld_ready);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (n > 0 && !fw) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else              m_starve = 0;
      if (fw) begin
        e      = mq.pop_front();
        m_wreg = e.r;
        m_wbus = e.d;
        m_rw   = (e.r != 0);
      end else if (alu_valid) begin
        m_wreg = alu_reg;
        m_wbus = alu_data;
        m_rw   = (alu_reg != 0);
      end else begin
        m_rw = 1'b0;
      end
      if (ld_valid && exp_ld_ready) begin
        e.r = ld_reg;
        e.d = ld_data;
        mq.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    alu_reg = '0; alu_data = '0; ld_reg = '0; ld_data = '0; query_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_we", RegWrite, 0);
    chk("rst_wreg", Write_Reg, 0);
    chk("rst_wbus", Write_Bus, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_qhit", query_hit, 0);
    chk("rst_qdata", query_data, 0);

    // Single ALU write
    alu_valid = 1'b1; alu_reg = 5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", RegWrite, 1);
    chk("alu_wreg", Write_Reg, 5);
    chk("alu_wbus", Write_Bus, 32'hDEADBEEF);
    alu_valid = 1'b0;
    step();
    chk("alu_we_drop", RegWrite, 0);
    chk("alu_wreg_hold", Write_Reg, 5);

    // Write to r0 is consumed but squashed
    alu_valid = 1'b1; alu_reg = 0; alu_data = 32'h12345678;
    step();
    chk("r0_ready", got_alu_ready, 1);
    chk("r0_we", RegWrite, 0);
    chk("r0_wbus", Write_Bus, 32'h12345678);
    alu_valid = 1'b0;
    step();
    chk("r0_we_after", RegWrite, 0);

    // Fill the FIFO while the ALU stays busy
    alu_valid = 1'b1; ld_valid = 1'b1; alu_reg = 1;
    for (int i = 0; i < 4; i++) begin
      ld_reg = AW'(8 + i); ld_data = 32'h100 + i; alu_data = i;
      step();
    end
    chk("fill_count", fifo_count, 4);
    chk("fill_ld_ready", ld_ready, 0);
    ld_reg = 12; ld_data = 32'h10C;
    step();
    chk("fill_alu_ready", got_alu_ready, 0);
    chk("fill_ld_blocked", got_ld_ready, 0);
    chk("fill_we", RegWrite, 1);
    chk("fill_wreg", Write_Reg, 8);
    step();
    chk("fill_ld_accept", got_ld_ready, 1);
    chk("fill_count_after", fifo_count, 4);
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (4) step();
    chk("fill_drained", fifo_count, 0);

    // Starvation guard
    ld_valid = 1'b1; ld_reg = 9; ld_data = 32'hA5A5A5A5;
    step();
    ld_valid = 1'b0; alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_reg = AW'(2 + i); alu_data = i;
      step();
      chk("starve_alu_win", got_alu_ready, 1);
      chk("starve_alu_wreg", Write_Reg, 2 + i);
    end
    alu_reg = 20; alu_data = 32'h55;
    step();
    chk("starve_alu_ready", got_alu_ready, 0);
    chk("starve_wreg", Write_Reg, 9);
    chk("starve_wbus", Write_Bus, 32'hA5A5A5A5);
    step();
    alu_valid = 1'b0;

    // Simultaneous push and pop at count 2
    alu_valid = 1'b1; alu_reg = 3; ld_valid = 1'b1; ld_reg = 14; ld_data = 32'hE;
    step();
    ld_reg = 15; ld_data = 32'hF;
    step();
    chk("pp_count_pre", fifo_count, 2);
    alu_valid = 1'b0; ld_reg = 16; ld_data = 32'h10;
    step();
    chk("pp_count", fifo_count, 2);
    chk("pp_wreg0", Write_Reg, 14);
    ld_valid = 1'b0;
    step();
    chk("pp_wreg1", Write_Reg, 15);
    step();
    chk("pp_wreg2", Write_Reg, 16);

    // Reset mid-stream
    alu_valid = 1'b1; alu_reg = 4; ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_reg = AW'(17 + i); ld_data = 32'h200 + i;
      step();
    end
    chk("rs_count_pre", fifo_count, 3);
    chk("rs_we_pre", RegWrite, 1);
    ld_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_we", RegWrite, 0);
    chk("rs_count", fifo_count, 0);
    chk("rs_ld_ready", ld_ready, 1);

    // Forwarding lookup with two pending writes to the same register
    alu_valid = 1'b1; alu_reg = 4; ld_valid = 1'b1; ld_reg = 9; ld_data = 1;
    step();
    ld_data = 2;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0; query_reg = 9;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_hit", query_hit, 1);
    chk("byp_data", query_data, 2);
`else
    chk("byp_hit_off", query_hit, 0);
    chk("byp_data_off", query_data, 0);
`endif
    query_reg = 0;
    #1;
    chk("byp_r0_miss", query_hit, 0);
    repeat (3) step();

    // Random traffic, sources hold payload until accepted
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(63) == 0);
      if (!alu_valid || exp_alu_ready) begin
        alu_valid = ($urandom_range(3) != 0);
        alu_reg   = AW'($urandom_range(7));
        alu_data  = $urandom;
      end
      if (!ld_valid || exp_ld_ready) begin
        ld_valid = $urandom_range(1);
        ld_reg   = AW'($urandom_range(7));
        ld_data  = $urandom;
      end
      query_reg = AW'($urandom_range(7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
